// File: rtl/sequenciador_giro_face_pkg.sv
// Shared constants for the cube-face servo sequencer: state codes and default timing.
package sequenciador_giro_face_pkg;

    localparam logic [3:0] INICIAL = 4'd0;
    localparam logic [3:0] FECHA   = 4'd1;
    localparam logic [3:0] GIRA    = 4'd2;
    localparam logic [3:0] ABRE    = 4'd3;
    localparam logic [3:0] VOLTA   = 4'd4;
    localparam logic [3:0] PROXIMO = 4'd5;
    localparam logic [3:0] FIM     = 4'd6;

    // 500 ms settle at 50 MHz
    localparam int unsigned T_SETTLE_PADRAO = 25_000_000;
    localparam int unsigned CLOCK_HZ        = 50_000_000;

endpackage

// File: rtl/sequenciador_giro_face_contador_m.sv
// Modulo-M counter with synchronous clear and enable; flags the terminal count M-1.
module sequenciador_giro_face_contador_m #(
    parameter int unsigned M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic fim_o
);

    localparam int unsigned W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] valor_q;
    logic [W-1:0] valor_d;

    assign fim_o = (valor_q == W'(M - 1));

    always_comb begin
        valor_d = valor_q;
        if (clr_i) begin
            valor_d = '0;
        end else if (en_i) begin
            valor_d = fim_o ? '0 : valor_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

endmodule

// File: rtl/sequenciador_giro_face.sv
// Cube-face station sequencer: closes gripper, rotates, opens, returns, repeated N times per command.
module sequenciador_giro_face
    import sequenciador_giro_face_pkg::*;
#(
    parameter int unsigned T_SETTLE = T_SETTLE_PADRAO,
    parameter int unsigned W_VEZES  = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [W_VEZES-1:0] vezes,
    output logic               posicao_garra,
    output logic               posicao_giro,
    output logic               pronto,
    output logic               fim,
    output logic [3:0]         db_estado
);

    logic [3:0]         estado_q;
    logic [3:0]         estado_d;
    logic [W_VEZES-1:0] contagem_q;
    logic [W_VEZES-1:0] contagem_d;
    logic               em_espera;
    logic               timer_fim;

    assign em_espera = (estado_q == FECHA) || (estado_q == GIRA) ||
                       (estado_q == ABRE)  || (estado_q == VOLTA);

    // Timer restarts on every state change so each move lasts exactly T_SETTLE cycles
    sequenciador_giro_face_contador_m #(
        .M (T_SETTLE)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .clr_i (!em_espera || timer_fim),
        .en_i  (em_espera),
        .fim_o (timer_fim)
    );

    always_comb begin
        estado_d   = estado_q;
        contagem_d = contagem_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    if (vezes != '0) begin
                        estado_d   = FECHA;
                        contagem_d = vezes;
                    end else begin
                        estado_d = FIM;
                    end
                end
            end
            FECHA:   if (timer_fim) estado_d = GIRA;
            GIRA:    if (timer_fim) estado_d = ABRE;
            ABRE:    if (timer_fim) estado_d = VOLTA;
            VOLTA:   if (timer_fim) estado_d = PROXIMO;
            PROXIMO: begin
                contagem_d = contagem_q - W_VEZES'(1);
                estado_d   = (contagem_q == W_VEZES'(1)) ? FIM : FECHA;
            end
            FIM:     estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            contagem_q <= '0;
        end else begin
            estado_q   <= estado_d;
            contagem_q <= contagem_d;
        end
    end

    always_comb begin
        posicao_garra = (estado_q == FECHA) || (estado_q == GIRA);
        posicao_giro  = (estado_q == GIRA)  || (estado_q == ABRE);
        pronto        = (estado_q == INICIAL);
        fim           = (estado_q == FIM);
        db_estado     = estado_q;
    end

endmodule
